// File: rtl/polar_frame_builder_if.sv
// Sample-stream bus for polar_frame_builder: enable, input samples and the
// framed output stream with its control strobes.
interface polar_frame_builder_if #(
  parameter int DATA_W = 1
);
  logic              enb;
  logic [DATA_W-1:0] dataIn;
  logic              validIn;
  logic [DATA_W-1:0] dataOut;
  logic              ctrlOut_start;
  logic              ctrlOut_end;
  logic              ctrlOut_valid;
  logic              frameEnd;
  logic              frameErr;
  logic              busy;

  modport master (
    output enb, dataIn, validIn,
    input  dataOut, ctrlOut_start, ctrlOut_end, ctrlOut_valid,
           frameEnd, frameErr, busy
  );

  modport slave (
    input  enb, dataIn, validIn,
    output dataOut, ctrlOut_start, ctrlOut_end, ctrlOut_valid,
           frameEnd, frameErr, busy
  );
endinterface

// File: rtl/polar_frame_builder.sv
// Groups a qualified sample stream into FRAME_LEN-sample frames with start/end
// strobes and a gap timeout. Define POLAR_FRAME_PAD_EN to zero-pad aborted frames.
//
// state | meaning
// IDLE  | waiting for the first sample of a frame
// RUN   | frame in progress, counting samples and idle cycles
// PAD   | (POLAR_FRAME_PAD_EN) emitting zero samples to finish an aborted frame
module polar_frame_builder #(
  parameter int DATA_W    = 1,
  parameter int FRAME_LEN = 1024,
  parameter int GAP_MAX   = 16
) (
  input logic                  clk,
  input logic                  reset_n,
  polar_frame_builder_if.slave pfb
);

  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam int GAP_W = (GAP_MAX > 0) ? $clog2(GAP_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_MAX > 0) ? GAP_MAX - 1 : 0);

`ifdef POLAR_FRAME_PAD_EN
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAD = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1} state_t;
`endif

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [GAP_W-1:0]  gap, gap_nxt;
  logic [DATA_W-1:0] data_q, data_nxt;
  logic              start_q, start_nxt;
  logic              end_q, end_nxt;
  logic              valid_q, valid_nxt;
  logic              err_q, err_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      gap     <= '0;
      data_q  <= '0;
      start_q <= 1'b0;
      end_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (pfb.enb) begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      gap     <= gap_nxt;
      data_q  <= data_nxt;
      start_q <= start_nxt;
      end_q   <= end_nxt;
      valid_q <= valid_nxt;
      err_q   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    gap_nxt   = gap;
    data_nxt  = '0;
    start_nxt = 1'b0;
    end_nxt   = 1'b0;
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (pfb.validIn) begin
          data_nxt  = pfb.dataIn;
          valid_nxt = 1'b1;
          start_nxt = 1'b1;
          gap_nxt   = '0;
          if (FRAME_LEN == 1) begin
            end_nxt = 1'b1;
            cnt_nxt = '0;
          end else begin
            cnt_nxt   = CNT_W'(1);
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        if (pfb.validIn) begin
          // an arriving sample always beats a pending timeout
          data_nxt  = pfb.dataIn;
          valid_nxt = 1'b1;
          gap_nxt   = '0;
          if (cnt == CNT_LAST) begin
            end_nxt   = 1'b1;
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end else if (GAP_MAX > 0) begin
          if (gap == GAP_LAST) begin
            err_nxt = 1'b1;
            gap_nxt = '0;
`ifdef POLAR_FRAME_PAD_EN
            state_nxt = PAD;
`else
            cnt_nxt   = '0;
            state_nxt = IDLE;
`endif
          end else begin
            gap_nxt = gap + GAP_W'(1);
          end
        end
      end
`ifdef POLAR_FRAME_PAD_EN
      PAD: begin
        // input samples are dropped; the count carries on from the aborted frame
        valid_nxt = 1'b1;
        if (cnt == CNT_LAST) begin
          end_nxt   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
`endif
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        gap_nxt   = '0;
      end
    endcase
  end

  assign pfb.dataOut       = data_q;
  assign pfb.ctrlOut_start = start_q;
  assign pfb.ctrlOut_end   = end_q;
  assign pfb.ctrlOut_valid = valid_q;
  assign pfb.frameEnd      = end_q;
  assign pfb.frameErr      = err_q;
  assign pfb.busy          = (state != IDLE);

endmodule

// File: tb/tb_polar_frame_builder.sv
// Bench for polar_frame_builder: two instances (FRAME_LEN=4 and FRAME_LEN=1,
// GAP_MAX=2) share one directed stimulus and are checked against a frame model.
module tb_polar_frame_builder;

  localparam int GAP = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  polar_frame_builder_if #(.DATA_W(8)) if4 ();
  polar_frame_builder_if #(.DATA_W(8)) if1 ();

  polar_frame_builder #(.DATA_W(8), .FRAME_LEN(4), .GAP_MAX(GAP)) dut4 (
    .clk(clk), .reset_n(reset_n), .pfb(if4)
  );
  polar_frame_builder #(.DATA_W(8), .FRAME_LEN(1), .GAP_MAX(GAP)) dut1 (
    .clk(clk), .reset_n(reset_n), .pfb(if1)
  );

  // packed view: {busy, frameErr, frameEnd, valid, end, start, data}
  logic [13:0] act [2];
  assign act[0] = {if4.busy, if4.frameErr, if4.frameEnd, if4.ctrlOut_valid,
                   if4.ctrlOut_end, if4.ctrlOut_start, if4.dataOut};
  assign act[1] = {if1.busy, if1.frameErr, if1.frameEnd, if1.ctrlOut_valid,
                   if1.ctrlOut_end, if1.ctrlOut_start, if1.dataOut};

  int total = 0;
  int bad = 0;

  int          m_pos [2];
  int          m_gap [2];
  bit          m_pad [2];
  logic [13:0] m_exp [2];

  function automatic logic [13:0] pk(input bit busy, input bit err, input bit fend,
                                     input bit vld, input bit en, input bit st,
                                     input logic [7:0] d);
    return {busy, err, fend, vld, en, st, d};
  endfunction

  task automatic chk(input string name, input logic [13:0] got, input logic [13:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h (busy,err,fend,valid,end,start,data)", name, got, want);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pos[k] = 0;
      m_gap[k] = 0;
      m_pad[k] = 1'b0;
      m_exp[k] = '0;
    end
  endtask

  // one enabled cycle of the frame model for instance k
  task automatic model_step(input int k, input bit v, input logic [7:0] d);
    int flen = (k == 0) ? 4 : 1;
    bit st = 1'b0, en = 1'b0, vo = 1'b0, er = 1'b0;
    logic [7:0] dq = '0;
    if (m_pad[k]) begin
      vo = 1'b1;
      m_pos[k]++;
      if (m_pos[k] == flen) begin
        en = 1'b1;
        m_pos[k] = 0;
        m_pad[k] = 1'b0;
      end
    end else if (v) begin
      vo = 1'b1;
      dq = d;
      st = (m_pos[k] == 0);
      m_pos[k]++;
      m_gap[k] = 0;
      if (m_pos[k] == flen) begin
        en = 1'b1;
        m_pos[k] = 0;
      end
    end else if (m_pos[k] > 0) begin
      m_gap[k]++;
      if (m_gap[k] == GAP) begin
        er = 1'b1;
        m_gap[k] = 0;
`ifdef POLAR_FRAME_PAD_EN
        m_pad[k] = 1'b1;
`else
        m_pos[k] = 0;
`endif
      end
    end
    m_exp[k] = {(m_pos[k] != 0) || m_pad[k], er, en, vo, en, st, dq};
  endtask

  task automatic drive(input bit e, input bit v, input logic [7:0] d);
    if4.enb = e; if4.validIn = v; if4.dataIn = d;
    if1.enb = e; if1.validIn = v; if1.dataIn = d;
  endtask

  task automatic cycle(input bit e, input bit v, input logic [7:0] d);
    drive(e, v, d);
    @(posedge clk);
    if (e) begin
      model_step(0, v, d);
      model_step(1, v, d);
    end
    #1;
  endtask

  task automatic pulse_reset();
    drive(1'b0, 1'b0, 8'd0);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("async_reset_len4", act[0], 14'd0);
    chk("async_reset_len1", act[1], 14'd0);
    #3;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    chk("model_len4", act[0], m_exp[0]);
    chk("model_len1", act[1], m_exp[1]);
  end

  initial begin
    model_reset();
    drive(1'b0, 1'b0, 8'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_len4", act[0], 14'd0);
    chk("reset_len1", act[1], 14'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: two back-to-back frames
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, 1'b1, 8'(i));
      if (i == 1) chk("t1_s1", act[0], pk(1, 0, 0, 1, 0, 1, 8'd1));
      if (i == 2) chk("t1_len1_s2", act[1], pk(0, 0, 1, 1, 1, 1, 8'd2));
      if (i == 4) chk("t1_s4_end", act[0], pk(0, 0, 1, 1, 1, 0, 8'd4));
      if (i == 5) chk("t1_s5_start", act[0], pk(1, 0, 0, 1, 0, 1, 8'd5));
      if (i == 8) chk("t1_s8_end", act[0], pk(0, 0, 1, 1, 1, 0, 8'd8));
    end
    cycle(1'b1, 1'b0, 8'hAA);
    chk("t1_idle", act[0], 14'd0);

    // 2: single-cycle gaps stay under the timeout
    cycle(1'b1, 1'b1, 8'd11);
    chk("t2_s1", act[0], pk(1, 0, 0, 1, 0, 1, 8'd11));
    cycle(1'b1, 1'b0, 8'h55);
    chk("t2_gap", act[0], pk(1, 0, 0, 0, 0, 0, 8'd0));
    cycle(1'b1, 1'b1, 8'd12);
    cycle(1'b1, 1'b0, 8'h55);
    cycle(1'b1, 1'b1, 8'd13);
    cycle(1'b1, 1'b0, 8'h55);
    cycle(1'b1, 1'b1, 8'd14);
    chk("t2_end", act[0], pk(0, 0, 1, 1, 1, 0, 8'd14));

    // valid wins over the timeout that would otherwise fire this cycle
    cycle(1'b1, 1'b1, 8'd31);
    cycle(1'b1, 1'b0, 8'h00);
    cycle(1'b1, 1'b1, 8'd32);
    chk("valid_wins", act[0], pk(1, 0, 0, 1, 0, 0, 8'd32));
    cycle(1'b1, 1'b1, 8'd33);
    cycle(1'b1, 1'b1, 8'd34);
    chk("valid_wins_end", act[0], pk(0, 0, 1, 1, 1, 0, 8'd34));

    // 3: timeout after two samples
    cycle(1'b1, 1'b1, 8'd21);
    cycle(1'b1, 1'b1, 8'd22);
    cycle(1'b1, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 8'h00);
`ifdef POLAR_FRAME_PAD_EN
    chk("t3_err", act[0], pk(1, 1, 0, 0, 0, 0, 8'd0));
    cycle(1'b1, 1'b1, 8'd23);
    chk("t3_pad1", act[0], pk(1, 0, 0, 1, 0, 0, 8'd0));
    cycle(1'b1, 1'b1, 8'd24);
    chk("t3_pad2_end", act[0], pk(0, 0, 1, 1, 1, 0, 8'd0));
`else
    chk("t3_err", act[0], pk(0, 1, 0, 0, 0, 0, 8'd0));
    cycle(1'b1, 1'b1, 8'd23);
    chk("t3_restart", act[0], pk(1, 0, 0, 1, 0, 1, 8'd23));
    cycle(1'b1, 1'b1, 8'd24);
    chk("t3_second", act[0], pk(1, 0, 0, 1, 0, 0, 8'd24));
`endif
    repeat (4) cycle(1'b1, 1'b0, 8'h00);

    // 4: FRAME_LEN=1 marks every sample as a whole frame
    for (int i = 71; i <= 73; i++) begin
      cycle(1'b1, 1'b1, 8'(i));
      chk("t4_len1", act[1], pk(0, 0, 1, 1, 1, 1, 8'(i)));
    end
    cycle(1'b1, 1'b1, 8'd74);
    chk("t4_len4_end", act[0], pk(0, 0, 1, 1, 1, 0, 8'd74));

    // 5: enable held low mid-frame with validIn high
    cycle(1'b1, 1'b1, 8'd41);
    cycle(1'b1, 1'b1, 8'd42);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 8'd99);
      chk("t5_hold", act[0], pk(1, 0, 0, 1, 0, 0, 8'd42));
    end
    cycle(1'b1, 1'b1, 8'd43);
    chk("t5_resume", act[0], pk(1, 0, 0, 1, 0, 0, 8'd43));
    cycle(1'b1, 1'b1, 8'd44);
    chk("t5_end", act[0], pk(0, 0, 1, 1, 1, 0, 8'd44));

    // 6: asynchronous reset after sample 2 discards the frame
    cycle(1'b1, 1'b1, 8'd51);
    cycle(1'b1, 1'b1, 8'd52);
    pulse_reset();
    cycle(1'b1, 1'b1, 8'd61);
    chk("t6_start", act[0], pk(1, 0, 0, 1, 0, 1, 8'd61));
    cycle(1'b1, 1'b1, 8'd62);
    cycle(1'b1, 1'b1, 8'd63);
    chk("t6_no_stale_end", act[0], pk(1, 0, 0, 1, 0, 0, 8'd63));
    cycle(1'b1, 1'b1, 8'd64);
    chk("t6_end", act[0], pk(0, 0, 1, 1, 1, 0, 8'd64));
    repeat (2) cycle(1'b1, 1'b0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
